// File: rtl/pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg
//   Two-entry pipeline register with a skid slot. in_ready comes straight from
//   a flop, so the upstream ready path is cut. out_data is driven directly
//   from the main register.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset (highest priority)
//   flush      synchronous discard of all held entries
//   in_valid   upstream offers in_data
//   in_ready   registered; block accepts in_data this cycle
//   in_data    upstream payload, WIDTH bits
//   out_valid  out_data holds a valid entry
//   out_ready  downstream consumes out_data this cycle
//   out_data   main register contents, WIDTH bits
//   count      number of held entries (0..2)
//
// States
//   state | meaning
//   ------+----------------------------------------------
//   EMPTY | nothing held, in_ready=1
//   BUSY  | main holds the head entry, in_ready=1
//   FULL  | main holds head, skid holds next, in_ready=0
// ----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             do_accept;
    logic             do_release;

    assign do_accept  = in_valid & in_ready;
    assign do_release = out_valid & out_ready;
    assign out_data   = main_q;

    // out_valid, count and in_ready are flops updated together with state so
    // they always agree with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= 2'd0;
        end else if (flush) begin
            // Register contents are left as they are; only occupancy clears.
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (do_accept) begin
                        state     <= BUSY;
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        count     <= 2'd1;
                    end
                end
                BUSY: begin
                    if (do_accept && do_release) begin
                        main_q <= in_data;
                    end else if (do_accept) begin
                        state    <= FULL;
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        count    <= 2'd2;
                    end else if (do_release) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        count     <= 2'd0;
                    end
                end
                FULL: begin
                    // in_ready is low here, so in_data is never taken.
                    if (do_release) begin
                        state    <= BUSY;
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        count    <= 2'd1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    count     <= 2'd0;
                end
            endcase
        end
    end

endmodule
